// File: rtl/dispatch_pkg.sv
// Shared definitions for the job dispatcher: FSM state encoding, default
// datapath sizes and the width of the START-phase hold/timeout counters.
package dispatch_pkg;

  localparam int unsigned DefDw    = 8;
  localparam int unsigned DefRw    = 16;
  localparam int unsigned DefDepth = 4;

  // Hold and timeout counters; TIMEOUT must stay below 2**CntW.
  localparam int unsigned CntW = 8;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StBusy
  } state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock operand FIFO.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   push, wdata     : write request and data; ignored while full
//   pop, rdata      : read request and head-of-queue data; ignored while empty
//   full, empty     : decoded from the registered occupancy count
//   count           : registered occupancy, 0..DEPTH
module sync_fifo #(
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] wdata,
  input  logic          pop,
  output logic [DW-1:0] rdata,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  localparam logic [AW:0] FullCnt = DEPTH[AW:0];

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push, do_pop;

  assign full    = (count_q == FullCnt);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset; occupancy alone defines valid entries.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/job_dispatcher.sv
// Initiator side of the start/ready coprocessor handshake. Operands are
// queued in a FIFO; each one is launched as a job on the arithmetic unit and
// its result is captured into a valid/ack output register.
// Ports:
//   clk, rst                  : clock, synchronous active-high reset
//   in_valid, in_data, in_ready : operand push interface
//   unit_start, unit_x        : job request and operand to the unit
//   unit_ready, unit_result   : unit idle/done flag and its result
//   res_valid, res_data, res_ack : captured result with consumer handshake
//   busy                      : job in flight or operands queued
//   err                       : sticky start-timeout flag
//   jobs_done                 : completed-job counter, wraps
module job_dispatcher
  import dispatch_pkg::*;
#(
  parameter int unsigned DW        = DefDw,
  parameter int unsigned RW        = DefRw,
  parameter int unsigned DEPTH     = DefDepth,
  parameter int unsigned START_CYC = 1,
  parameter int unsigned TIMEOUT   = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          unit_start,
  output logic [DW-1:0] unit_x,
  input  logic          unit_ready,
  input  logic [RW-1:0] unit_result,
  output logic          res_valid,
  output logic [RW-1:0] res_data,
  input  logic          res_ack,
  output logic          busy,
  output logic          err,
  output logic [7:0]    jobs_done
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [CntW-1:0] HoldMin     = CntW'(START_CYC - 1);
  localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [DW-1:0]   x_q, x_d;
  logic [CntW-1:0] hold_q, hold_d;
  logic [CntW-1:0] to_q, to_d;
  logic            res_valid_q, res_valid_d;
  logic [RW-1:0]   res_data_q, res_data_d;
  logic            err_q, err_d;
  logic [7:0]      jobs_q, jobs_d;

  logic            fifo_pop;
  logic [DW-1:0]   fifo_rdata;
  logic            fifo_full, fifo_empty;
  logic [AW:0]     fifo_count;

  sync_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_valid),
    .wdata (in_data),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    hold_d      = hold_q;
    to_d        = to_q;
    res_valid_d = res_valid_q & ~res_ack;
    res_data_d  = res_data_q;
    err_d       = err_q;
    jobs_d      = jobs_q;
    fifo_pop    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          x_d      = fifo_rdata;
          hold_d   = '0;
          to_d     = '0;
          state_d  = StStart;
        end
      end
      StStart: begin
        if (hold_q != '1) hold_d = hold_q + 1'b1;
        if (to_q != '1)   to_d   = to_q + 1'b1;
        // A high ready here is the unit's idle state, never a completion.
        if (hold_q >= HoldMin && !unit_ready) begin
          state_d = StBusy;
        end else if (unit_ready && to_q >= TimeoutLast) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end
      end
      StBusy: begin
        // The unit keeps its result while idle, so a full result slot just stalls here.
        if (unit_ready && (!res_valid_q || res_ack)) begin
          res_data_d  = unit_result;
          res_valid_d = 1'b1;
          jobs_d      = jobs_q + 8'd1;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      x_q         <= '0;
      hold_q      <= '0;
      to_q        <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      err_q       <= 1'b0;
      jobs_q      <= '0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      hold_q      <= hold_d;
      to_q        <= to_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      err_q       <= err_d;
      jobs_q      <= jobs_d;
    end
  end

  assign in_ready   = ~fifo_full;
  assign unit_start = (state_q == StStart);
  assign unit_x     = x_q;
  assign res_valid  = res_valid_q;
  assign res_data   = res_data_q;
  assign busy       = (state_q != StIdle) || (fifo_count != '0);
  assign err        = err_q;
  assign jobs_done  = jobs_q;

endmodule
